// File: rtl/rst_seq_pkg.sv
// Reset sequencer shared types: FSM state encoding and parameter defaults.
// Imported by rst_seq_gen and its testbench.
package rst_seq_pkg;

    localparam int unsigned HOLD_CYCLES_DEF = 16;
    localparam int unsigned STAGE_GAP_DEF   = 8;
    localparam int unsigned LOCK_FILTER_DEF = 4;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rst_seq_gen_sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer, async reset to 0.
// Ports: clk, rst_asyn (active-high), d (async in), q (synchronized out).
module sync_2ff (
    input  logic clk,
    input  logic rst_asyn,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staged reset sequencer gated by a filtered PLL lock.
// Ports: clk, rst_asyn (async, active-high), pll_locked, sw_rst_req (async
// inputs); rst_stage[2:0] (bit 0 released first), rst_done, busy (outputs).
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int unsigned STAGE_GAP   = STAGE_GAP_DEF,
    parameter int unsigned LOCK_FILTER = LOCK_FILTER_DEF
) (
    input  logic       clk,
    input  logic       rst_asyn,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    output logic [2:0] rst_stage,
    output logic       rst_done,
    output logic       busy
);

    // Hold and gap counters only ever reach MAX-1; lock counter reaches MAX.
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES);
    localparam int unsigned GAP_W  = $clog2(STAGE_GAP + 1);
    localparam int unsigned LOCK_W = $clog2(LOCK_FILTER + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_FILTER);

    logic lock_sync;
    logic sw_sync;

    sync_2ff u_sync_lock (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .d        (pll_locked),
        .q        (lock_sync)
    );

    sync_2ff u_sync_sw (
        .clk      (clk),
        .rst_asyn (rst_asyn),
        .d        (sw_rst_req),
        .q        (sw_sync)
    );

    seq_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              sw_prev_q, sw_prev_d;
    logic [2:0]        stage_q, stage_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic lock_ok;
    logic sw_req;
    logic go_assert;

    assign lock_ok = (lock_cnt_q == LOCK_MAX);
    assign sw_req  = sw_sync & ~sw_prev_q;

    always_comb begin
        sw_prev_d  = sw_sync;
        lock_cnt_d = lock_cnt_q;
        if (!lock_sync) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_MAX) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        stage_d   = stage_q;
        done_d    = done_q;
        busy_d    = busy_q;
        go_assert = 1'b0;

        unique case (state_q)
            ST_ASSERT: begin
                stage_d = 3'b111;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                // Lock loss is ignored here; only a sw request restarts.
                if (sw_req) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    state_d = ST_WAIT_LOCK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                if (sw_req) begin
                    go_assert = 1'b1;
                end else if (lock_ok) begin
                    state_d = ST_RELEASE;
                    stage_d = 3'b110;
                    gap_d   = '0;
                end
            end
            ST_RELEASE: begin
                if (sw_req || !lock_ok) begin
                    go_assert = 1'b1;
                end else if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (stage_q[1]) begin
                        stage_d = 3'b100;
                    end else begin
                        stage_d = 3'b000;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_RUN;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (sw_req || !lock_ok) begin
                    go_assert = 1'b1;
                end
            end
            default: begin
                go_assert = 1'b1;
            end
        endcase

        if (go_assert) begin
            state_d = ST_ASSERT;
            stage_d = 3'b111;
            done_d  = 1'b0;
            busy_d  = 1'b1;
            hold_d  = '0;
            gap_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_asyn) begin
        if (rst_asyn) begin
            state_q    <= ST_ASSERT;
            hold_q     <= '0;
            gap_q      <= '0;
            lock_cnt_q <= '0;
            sw_prev_q  <= 1'b0;
            stage_q    <= 3'b111;
            done_q     <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            lock_cnt_q <= lock_cnt_d;
            sw_prev_q  <= sw_prev_d;
            stage_q    <= stage_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign rst_stage = stage_q;
    assign rst_done  = done_q;
    assign busy      = busy_q;

endmodule

// File: doc/rst_seq_gen.md
RST_SEQ_GEN -- requirements
Module: rst_seq_gen

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 16, setting the minimum all-stage reset assertion in clk cycles (range 2..65535).
REQ-002 The block SHALL have parameter STAGE_GAP, default 8, setting the clk cycles between successive stage releases (range 1..65535).
REQ-003 The block SHALL have parameter LOCK_FILTER, default 4, setting the consecutive synchronized-high cycles required to accept pll_locked (range 1..255).
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock.
REQ-005 The block SHALL have port rst_asyn, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port pll_locked, input, 1 bit: asynchronous clock-source lock status.
REQ-007 The block SHALL have port sw_rst_req, input, 1 bit: asynchronous software reset request, acted on at its rising edge.
REQ-008 The block SHALL have port rst_stage, output, 3 bits: active-high sequenced resets; bit 0 releases first, bit 2 last.
REQ-009 The block SHALL have port rst_done, output, 1 bit: high when all stages are released.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except RUN.

Function
REQ-011 pll_locked and sw_rst_req SHALL each pass through a 2-flop synchronizer before use.
REQ-012 sw_rst_req SHALL be rising-edge detected after synchronization: one request per 0->1 transition.
REQ-013 The lock filter SHALL run in every state: its counter increments while synchronized lock is 1, saturates at LOCK_FILTER, and clears to 0 on any 0; lock_ok = (count == LOCK_FILTER).
REQ-014 The FSM SHALL have states ASSERT, WAIT_LOCK, RELEASE and RUN.
REQ-015 ASSERT: rst_stage=3'b111; hold counter counts clk edges; on the HOLD_CYCLES-th edge, transition to WAIT_LOCK.
REQ-016 WAIT_LOCK: rst_stage=3'b111; on an edge with lock_ok=1, transition to RELEASE and register rst_stage[0]=0 on that same edge.
REQ-017 RELEASE: rst_stage[1] SHALL deassert STAGE_GAP edges after rst_stage[0], and rst_stage[2] STAGE_GAP edges after rst_stage[1]; on the rst_stage[2] edge, go to RUN with rst_done=1.
REQ-018 Once deasserted, a stage SHALL stay deasserted until the next ASSERT entry (no glitches).
REQ-019 A software request, or lock_ok falling to 0, in WAIT_LOCK, RELEASE or RUN SHALL cause an ASSERT entry on the next edge: rst_stage=3'b111, rst_done=0, hold counter cleared.
REQ-020 A software request in ASSERT SHALL restart the hold counter; lock loss in ASSERT SHALL have no effect.
REQ-021 A software request and lock loss on the same cycle SHALL cause a single ASSERT entry.
REQ-022 All outputs SHALL be driven directly from flops.
REQ-023 Counters SHALL be sized with clog2 of their maximum and SHALL NOT wrap.

Reset
REQ-024 rst_asyn high SHALL immediately and asynchronously force state=ASSERT, rst_stage=3'b111, rst_done=0, busy=1, and all counters and synchronizer flops to 0.
REQ-025 rst_asyn asserted mid-sequence (any state) SHALL abort the sequence; the full sequence restarts from ASSERT on deassertion.
REQ-026 The first clk edge with rst_asyn low SHALL count as hold edge 1.

Structure
REQ-027 Package rst_seq_pkg SHALL hold the FSM state encoding and the parameter default constants.
REQ-028 One sub-module, sync_2ff (1-bit, asynchronously reset to 0), SHALL be instantiated once for pll_locked and once for sw_rst_req.

Verification
REQ-029 Power-up (defaults, pll_locked=1 throughout, rst_asyn high 5 cycles then low) -> rst_stage[0] falls at edge 17, rst_stage[1] at edge 25, rst_stage[2] with rst_done=1 and busy=0 at edge 33.
REQ-030 Late lock (pll_locked rises at edge 40) -> rst_stage stays 3'b111 until lock_ok, then releases in order at 8-cycle spacing.
REQ-031 Lock glitch (pll_locked low 1 cycle in RUN) -> rst_stage=3'b111 and rst_done=0 within 4 edges; full sequence repeats.
REQ-032 sw_rst_req held high 50 cycles -> exactly one ASSERT entry; the sequence then completes.
REQ-033 rst_asyn pulsed high mid-RELEASE -> outputs reset immediately (no clock); full 16-cycle hold then re-release.
REQ-034 Simultaneous sw_rst_req edge and lock loss in RUN -> a single ASSERT entry; no stage toggles in between.
